// File: rtl/store_packer.sv
// Store packer: narrows sb/sh/sw data onto the 32-bit memory bus with byte enables and queues it.
// Optional STORE_PACKER_MERGE_EN merges aligned stores into the newest non-head entry of the same word.
module store_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [1:0]               st_op,
  input  logic [31:0]              st_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misalign,
  output logic [31:0]              misalign_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic [3:0]    req_be;
  logic [31:0]   req_data;
  logic          bad;
  logic          merge;
  logic          accept;
  logic          do_alloc;
  logic          do_merge;
  logic          pop;
  logic          has_room;

  // Lane placement and alignment check for the incoming request
  always_comb begin
    req_be   = 4'b0000;
    req_data = 32'h0;
    bad      = 1'b0;
    unique case (st_op)
      2'd0: begin
        req_be   = 4'b1111;
        req_data = st_data;
        bad      = |st_addr[1:0];
      end
      2'd1: begin
        req_be   = 4'b0011 << st_addr[1:0];
        req_data = {2{st_data[15:0]}};
        bad      = st_addr[0];
      end
      2'd2: begin
        req_be   = 4'b0001 << st_addr[1:0];
        req_data = {4{st_data[7:0]}};
      end
      default: bad = 1'b1;
    endcase
  end

`ifdef STORE_PACKER_MERGE_EN
  logic [AW-1:0] newest;
  logic [31:0]   merged;

  // Merge hit against the newest entry, only when it is not the head
  always_comb begin
    newest = wptr - 1'b1;
    merge  = !bad && (count >= (AW+1)'(2))
             && (addr_q[newest] == st_addr[31:2]);
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = req_be[i] ? req_data[8*i +: 8]
                                   : data_q[newest][8*i +: 8];
  end
`else
  assign merge = 1'b0;
`endif

  assign has_room  = (count < CAP);
  assign st_ready  = has_room || merge;
  assign accept    = st_valid && st_ready;
  assign do_merge  = accept && merge;
  assign do_alloc  = accept && !bad && !merge;
  assign mem_valid = (count != '0);
  assign pop       = mem_valid && mem_ready;
  assign mem_addr  = mem_valid ? {addr_q[rptr], 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? data_q[rptr] : 32'h0;
  assign mem_be    = mem_valid ? be_q[rptr] : 4'b0000;

  // Occupancy and ring pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (do_alloc) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      unique case ({do_alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are masked by count so no reset is needed
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      addr_q[wptr] <= st_addr[31:2];
      data_q[wptr] <= req_data;
      be_q[wptr]   <= req_be;
    end
`ifdef STORE_PACKER_MERGE_EN
    if (do_merge) begin
      data_q[newest] <= merged;
      be_q[newest]   <= be_q[newest] | req_be;
    end
`endif
  end

  // One-cycle misalign pulse with the offending address captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign      <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      misalign <= accept && bad;
      if (accept && bad) misalign_addr <= st_addr;
    end
  end

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer with hand-computed expectations.
// Covers packing, misalign pulse, backpressure, full push/pop, async reset, optional merge.
module tb_store_packer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [1:0]  st_op;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  store_packer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_op(st_op), .st_data(st_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign(misalign), .misalign_addr(misalign_addr),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] op,
                      input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_op    = op;
    st_data  = d;
    step();
    st_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_op = '0;
    st_data = '0; mem_ready = 1'b0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(mem_valid), 0);
    check("rst_be", 32'(mem_be), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_mis", 32'(misalign), 0);
    check("rst_ready", 32'(st_ready), 1);
    reset = 1'b0;
    step();

    mem_ready = 1'b1;
    push(32'h3, 2'd2, 32'h0000_00A5);
    check("sb_valid", 32'(mem_valid), 1);
    check("sb_addr", mem_addr, 32'h0);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_count", 32'(count), 1);
    step();
    check("sb_drained", 32'(count), 0);
    check("sb_idle", 32'(mem_valid), 0);

    mem_ready = 1'b0;
    push(32'h1002, 2'd1, 32'hFFFF_1234);
    check("sh_be", 32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'h1234_1234);
    check("sh_addr", mem_addr, 32'h1000);
    mem_ready = 1'b1;
    step();
    check("sh_drained", 32'(count), 0);

    push(32'h6, 2'd0, 32'hDEAD_BEEF);
    check("mis_pulse", 32'(misalign), 1);
    check("mis_addr", misalign_addr, 32'h6);
    check("mis_count", 32'(count), 0);
    check("mis_noval", 32'(mem_valid), 0);
    step();
    check("mis_end", 32'(misalign), 0);
    push(32'h8, 2'd3, 32'h1);
    check("rsv_pulse", 32'(misalign), 1);
    check("rsv_addr", misalign_addr, 32'h8);
    check("rsv_count", 32'(count), 0);
    step();
    check("rsv_end", 32'(misalign), 0);

    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h10 + 32'(4*i), 2'd0, 32'hA000_0000 + 32'(i));
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(st_ready), 0);
    st_valid = 1'b1; st_addr = 32'h30; st_op = 2'd0; st_data = 32'h55;
    step();
    check("held_count", 32'(count), 4);
    check("stall_addr", mem_addr, 32'h10);
    check("stall_data", mem_wdata, 32'hA000_0000);
    mem_ready = 1'b1;
    step();
    st_valid = 1'b0;
    check("pp_count", 32'(count), 3);
    check("pp_ready", 32'(st_ready), 1);
    for (int i = 1; i < 4; i++) begin
      check("ord_addr", mem_addr, 32'h10 + 32'(4*i));
      check("ord_data", mem_wdata, 32'hA000_0000 + 32'(i));
      step();
    end
    check("ord_empty", 32'(count), 0);

    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h40 + 32'(4*i), 2'd0, 32'h1 + 32'(i));
    check("pre_rst_cnt", 32'(count), 3);
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(mem_valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_be", 32'(mem_be), 0);
    reset = 1'b0;
    step();

    push(32'h20, 2'd0, 32'h1122_3344);
    push(32'h41, 2'd2, 32'h0000_0077);
    push(32'h42, 2'd2, 32'h0000_0088);
`ifdef STORE_PACKER_MERGE_EN
    check("mg_count", 32'(count), 2);
    mem_ready = 1'b1;
    check("mg_h0_addr", mem_addr, 32'h20);
    check("mg_h0_be", 32'(mem_be), 32'hF);
    step();
    check("mg_h1_addr", mem_addr, 32'h40);
    check("mg_h1_be", 32'(mem_be), 32'h6);
    check("mg_h1_data", mem_wdata, 32'h7788_7777);
    step();
    check("mg_empty", 32'(count), 0);
`else
    check("nm_count", 32'(count), 3);
    mem_ready = 1'b1;
    check("nm_h0_addr", mem_addr, 32'h20);
    check("nm_h0_data", mem_wdata, 32'h1122_3344);
    step();
    check("nm_h1_be", 32'(mem_be), 32'h2);
    check("nm_h1_data", mem_wdata, 32'h7777_7777);
    step();
    check("nm_h2_addr", mem_addr, 32'h40);
    check("nm_h2_be", 32'(mem_be), 32'h4);
    check("nm_h2_data", mem_wdata, 32'h8888_8888);
    step();
    check("nm_empty", 32'(count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
